// File: rtl/seq_mult_if.sv
// seq_mult_if: operand/result handshake bundle for seq_mult.
//   in_valid/in_ready  - operand request handshake (a, b, is_signed)
//   out_valid/out_ready - product handshake (product, 2*WIDTH bits)
// master: the requester/consumer side; slave: the multiplier.
interface seq_mult_if #(
  parameter int WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 is_signed;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/seq_mult.sv
// seq_mult: iterative radix-2 shift-and-add multiplier, one multiplier bit
// per clock, full 2*WIDTH-bit product, signed or unsigned operands.
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - seq_mult_if slave: in_valid/in_ready/a/b/is_signed in,
//          out_valid/out_ready/product out
// Latency is fixed: operands accepted at edge T give out_valid after T+WIDTH.
module seq_mult #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  seq_mult_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   sum;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 last_bit;

  // Magnitudes are taken as WIDTH-bit unsigned, so the most-negative operand
  // becomes 2^(WIDTH-1) and the sign is reapplied to the final product.
  always_comb begin
    a_mag = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_mag = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  end

  always_comb begin
    sum      = acc_q + (mplier_q[0] ? mcand_q : '0);
    cnt_inc  = cnt_q + CNT_W'(1);
    last_bit = (cnt_inc == CNT_W'(WIDTH));
  end

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = BUSY;
      BUSY:    if (last_bit)      state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          mplier_d = a_mag;
          mcand_d  = {{WIDTH{1'b0}}, b_mag};
          acc_d    = '0;
          cnt_d    = '0;
          neg_d    = bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        end
      end
      BUSY: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_inc;
        if (last_bit) begin
          product_d = neg_q ? -sum : sum;
        end
      end
      default: ;
    endcase
  end

  // Outputs depend on state only; in_ready never follows out_ready
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.product   = product_q;
  end

endmodule

// File: tb/tb_seq_mult.sv
module tb_seq_mult;

  logic clk;
  logic rst;
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned failures = 0;

  seq_mult_if #(.WIDTH(32)) if32 ();
  seq_mult_if #(.WIDTH(8))  if8 ();

  seq_mult #(.WIDTH(32)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (if32)
  );

  seq_mult #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: sign-extend to 128 bits, multiply, keep 2*w bits.
  function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                           input bit sgn, input int unsigned w);
    logic [127:0] ea, eb, wmask, pmask;
    wmask = (128'd1 << w) - 128'd1;
    pmask = (128'd1 << (2 * w)) - 128'd1;
    ea = {64'd0, a} & wmask;
    eb = {64'd0, b} & wmask;
    if (sgn && a[w-1]) ea = ea | ~wmask;
    if (sgn && b[w-1]) eb = eb | ~wmask;
    return (ea * eb) & pmask;
  endfunction

  task automatic run32(input logic [31:0] ta, input logic [31:0] tb_v, input bit sgn,
                       input string tag);
    int unsigned n;
    logic [127:0] exp;
    exp = ref_mul(64'(ta), 64'(tb_v), sgn, 32);
    @(negedge clk);
    check({tag, "_rdy"}, 128'(if32.in_ready), 128'd1);
    if32.a = ta;
    if32.b = tb_v;
    if32.is_signed = sgn;
    if32.in_valid = 1'b1;
    if32.out_ready = 1'b1;
    @(negedge clk);
    // scramble inputs after the accept edge; result must not change
    if32.in_valid = 1'b0;
    if32.a = $urandom;
    if32.b = $urandom;
    if32.is_signed = ~sgn;
    n = 0;
    while (!if32.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, 128'(n), 128'd32);
    check({tag, "_prod"}, 128'(if32.product), exp);
    @(negedge clk);
    check({tag, "_idle"}, 128'({if32.in_ready, if32.out_valid}), 128'b10);
  endtask

  initial begin
    logic [127:0] exp;
    logic [63:0] held;
    int unsigned n;
    int unsigned acc_e [4];
    bit busy_ok;

    rst = 1'b1;
    if32.in_valid = 1'b0; if32.a = '0; if32.b = '0; if32.is_signed = 1'b0; if32.out_ready = 1'b0;
    if8.in_valid = 1'b0;  if8.a = '0;  if8.b = '0;  if8.is_signed = 1'b0;  if8.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst32_state", 128'({if32.in_ready, if32.out_valid}), 128'b10);
    check("rst32_prod", 128'(if32.product), 128'd0);
    check("rst8_state", 128'({if8.in_ready, if8.out_valid}), 128'b10);
    rst = 1'b0;

    // Directed operands
    run32(32'd128, 32'd128, 1'b0, "u128sq");
    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "u_max");
    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "s_m1m1");
    run32(32'hFFFF_FFFD, 32'd5, 1'b1, "s_m3x5");
    run32(32'h8000_0000, 32'h8000_0000, 1'b1, "s_minsq");
    run32(32'h8000_0000, 32'd1, 1'b1, "s_minx1");
    run32(32'd0, 32'd0, 1'b0, "zero");
    check("ref_const", ref_mul(64'h8000_0000, 64'h8000_0000, 1'b1, 32), 128'h4000_0000_0000_0000);

    // Random operands, including signed/unsigned mix
    for (int i = 0; i < 6; i++) begin
      run32($urandom, $urandom, 1'($urandom_range(0, 1)), "rand32");
    end

    // Backpressure: hold out_ready low while inputs churn
    @(negedge clk);
    if32.out_ready = 1'b0;
    if32.a = 32'h1234_5678;
    if32.b = 32'hDEAD_BEEF;
    if32.is_signed = 1'b1;
    if32.in_valid = 1'b1;
    exp = ref_mul(64'h1234_5678, 64'hDEAD_BEEF, 1'b1, 32);
    @(negedge clk);
    if32.in_valid = 1'b0;
    n = 0;
    while (!if32.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_lat", 128'(n), 128'd32);
    check("bp_prod", 128'(if32.product), exp);
    held = if32.product;
    for (int k = 0; k < 5; k++) begin
      if32.a = $urandom;
      if32.b = $urandom;
      if32.in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("bp_hold_state", 128'({if32.out_valid, if32.in_ready}), 128'b10);
      check("bp_hold_prod", 128'(if32.product), 128'(held));
    end
    if32.in_valid = 1'b0;
    if32.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", 128'({if32.in_ready, if32.out_valid}), 128'b10);
    @(negedge clk);
    check("bp_stay_idle", 128'({if32.in_ready, if32.out_valid}), 128'b10);

    // Reset mid-operation at counter=10
    if32.a = 32'd99; if32.b = 32'd77; if32.is_signed = 1'b0; if32.in_valid = 1'b1;
    @(negedge clk);
    if32.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_busy", 128'({if32.in_ready, if32.out_valid}), 128'b00);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_state", 128'({if32.in_ready, if32.out_valid}), 128'b10);
    check("mid_rst_prod", 128'(if32.product), 128'd0);
    run32(32'd7, 32'd6, 1'b0, "after_rst");

    // Reset and in_valid together: operands dropped
    @(negedge clk);
    rst = 1'b1;
    if32.in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if32.in_valid = 1'b0;
    check("rst_vs_valid", 128'({if32.in_ready, if32.out_valid}), 128'b10);
    @(negedge clk);
    check("rst_vs_valid2", 128'({if32.in_ready, if32.out_valid}), 128'b10);

    // Back-to-back on the 8-bit instance with in_valid held high
    if8.a = $urandom; if8.b = $urandom; if8.is_signed = 1'($urandom_range(0, 1));
    if8.in_valid = 1'b1;
    if8.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!if8.in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("b2b_rdy", 128'(if8.in_ready), 128'd1);
      acc_e[i] = cyc + 1;
      exp = ref_mul(64'(if8.a), 64'(if8.b), if8.is_signed, 8);
      @(negedge clk);
      // next request presented during BUSY; must be held off until IDLE
      if8.a = $urandom; if8.b = $urandom; if8.is_signed = 1'($urandom_range(0, 1));
      busy_ok = 1'b1;
      n = 0;
      while (!if8.out_valid && n < 50) begin
        if (if8.in_ready) busy_ok = 1'b0;
        @(negedge clk);
        n++;
      end
      check("b2b_busy_rdy_low", 128'(busy_ok), 128'd1);
      check("b2b_lat", 128'(cyc - acc_e[i]), 128'd8);
      check("b2b_prod", 128'(if8.product), exp);
      if (i > 0) check("b2b_spacing", 128'(acc_e[i] - acc_e[i-1]), 128'd10);
    end
    if8.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("b2b_end_idle", 128'({if8.in_ready, if8.out_valid}), 128'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
